// File: rtl/enum_state_tracker.sv
// enum_state_tracker: locks onto the ts0->ts1->ts2 state stream, counts wraps, flags errors.
// Optional immediate assertions are compiled in with `define ENUM_TRACK_ASSERT_EN.
module enum_state_tracker #(
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_clr,
  input  logic             in_valid,
  input  logic [1:0]       in_state,
  output logic [1:0]       exp_state,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [1:0]       bad_cnt
);

  typedef enum logic [1:0] {T_IDLE, T_LOCK, T_ERR} trk_t;

  localparam logic [1:0] TS0 = 2'd0;
  localparam logic [1:0] TS1 = 2'd1;
  localparam logic [1:0] TS2 = 2'd2;
  localparam logic [1:0] TS3 = 2'd3;
  localparam logic [2:0] LIM = 3'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  trk_t             state, state_n;
  logic [1:0]       last, last_n;
  logic [1:0]       exp_n, bad_n;
  logic [CNT_W-1:0] wrap_n;
  logic [2:0]       bad_inc;

  function automatic logic [1:0] next_ts(input logic [1:0] s);
    unique case (s)
      TS0:     next_ts = TS1;
      TS1:     next_ts = TS2;
      default: next_ts = TS0;
    endcase
  endfunction

  assign bad_inc = {1'b0, bad_cnt} + 3'd1;

  always_comb begin
    state_n = state;
    exp_n   = exp_state;
    last_n  = last;
    bad_n   = bad_cnt;
    wrap_n  = wrap_cnt;
    if (sync_clr) begin
      state_n = T_IDLE;
      exp_n   = TS0;
      last_n  = TS0;
      bad_n   = 2'd0;
      wrap_n  = '0;
    end else if (in_valid) begin
      unique case (state)
        T_IDLE: begin
          if (in_state == TS0) begin
            state_n = T_LOCK;
            last_n  = TS0;
            exp_n   = TS1;
          end else if (in_state == TS3) begin
            state_n = T_ERR;
          end
        end
        T_LOCK: begin
          // last and exp_state always differ and never hold ts3
          unique case (1'b1)
            (in_state == exp_state): begin
              last_n = in_state;
              exp_n  = next_ts(in_state);
              bad_n  = 2'd0;
              if (in_state == TS0 && !(&wrap_cnt))
                wrap_n = wrap_cnt + ONE;
            end
            (in_state == last): bad_n = 2'd0;
            (in_state == TS3):  state_n = T_ERR;
            default: begin
              bad_n = bad_inc[1:0];
              if (bad_inc >= LIM)
                state_n = T_ERR;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= T_IDLE;
      exp_state <= TS0;
      last      <= TS0;
      bad_cnt   <= 2'd0;
      wrap_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      exp_state <= exp_n;
      last      <= last_n;
      bad_cnt   <= bad_n;
      wrap_cnt  <= wrap_n;
      locked    <= (state_n == T_LOCK);
      err       <= (state_n == T_ERR);
    end
  end

`ifdef ENUM_TRACK_ASSERT_EN
  always @(*) begin
    assert (exp_state != 2'h3);
    assert (!(locked && err));
    assert ({1'b0, bad_cnt} < LIM || err);
    assert (state != 2'h3);
  end
`else
`endif

endmodule

// File: tb/tb_enum_state_tracker.sv
// tb_enum_state_tracker: directed and random checks against a behavioural model.
// Two instances share stimulus: default widths and a 2-bit wrap counter.
module tb_enum_state_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync_clr;
  logic       in_valid;
  logic [1:0] in_state;

  logic [1:0] exp_state, exp_state2;
  logic       locked, locked2;
  logic       err, err2;
  logic [7:0] wrap_cnt;
  logic [1:0] wrap_cnt2;
  logic [1:0] bad_cnt, bad_cnt2;

  enum_state_tracker #(.CNT_W(8), .ERR_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr),
    .in_valid(in_valid), .in_state(in_state),
    .exp_state(exp_state), .locked(locked), .err(err),
    .wrap_cnt(wrap_cnt), .bad_cnt(bad_cnt)
  );

  enum_state_tracker #(.CNT_W(2), .ERR_LIMIT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr),
    .in_valid(in_valid), .in_state(in_state),
    .exp_state(exp_state2), .locked(locked2), .err(err2),
    .wrap_cnt(wrap_cnt2), .bad_cnt(bad_cnt2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model: mode 0 idle, 1 locked, 2 error
  int m_mode, m_exp, m_last, m_bad, m_wrap, m_wrap2;

  function automatic logic [13:0] want_a();
    return {2'(m_exp), m_mode == 1, m_mode == 2, 2'(m_bad), 8'(m_wrap)};
  endfunction

  function automatic logic [7:0] want_b();
    return {2'(m_exp), m_mode == 1, m_mode == 2, 2'(m_bad), 2'(m_wrap2)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_last = 0;
    m_bad = 0; m_wrap = 0; m_wrap2 = 0;
  endtask

  task automatic model_step(input bit v, input int s, input bit c);
    if (c) model_reset();
    else if (v) begin
      if (m_mode == 0) begin
        if (s == 0) begin m_mode = 1; m_last = 0; m_exp = 1; end
        else if (s == 3) m_mode = 2;
      end else if (m_mode == 1) begin
        if (s == m_exp) begin
          if (s == 0) begin
            if (m_wrap < 255) m_wrap++;
            if (m_wrap2 < 3) m_wrap2++;
          end
          m_last = s;
          m_exp = (s + 1) % 3;
          m_bad = 0;
        end else if (s == m_last) m_bad = 0;
        else if (s == 3) m_mode = 2;
        else begin
          m_bad++;
          if (m_bad >= 3) m_mode = 2;
        end
      end
    end
  endtask

  task automatic cyc(input bit v, input int s, input bit c);
    in_valid = v; in_state = 2'(s); sync_clr = c;
    @(posedge clk); #1;
    model_step(v, s, c);
    in_valid = 1'b0; sync_clr = 1'b0;
  endtask

  function automatic logic [13:0] got_a();
    return {exp_state, locked, err, bad_cnt, wrap_cnt};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; sync_clr = 1'b0; in_valid = 1'b0; in_state = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (got_a() !== 14'h0) begin
      bad++; $display("FAIL reset_hold got=%h want=%h", got_a(), 14'h0);
    end
    rst_n = 1'b1;
    repeat (10) cyc(0, 0, 0);
    total++;
    if (got_a() !== 14'h0 || wrap_cnt2 !== 2'd0) begin
      bad++; $display("FAIL reset_idle got=%h want=%h", got_a(), 14'h0);
    end
  endtask

  task automatic test_wrap();
    int seq[7] = '{0, 1, 2, 0, 1, 2, 0};
    for (int i = 0; i < 7; i++) begin
      cyc(1, seq[i], 0);
      if (i == 0) begin
        total++;
        if (locked !== 1'b1) begin
          bad++; $display("FAIL wrap_lock got=%b want=1", locked);
        end
      end
    end
    total++;
    if ({exp_state, locked, err, wrap_cnt} !== {2'd1, 1'b1, 1'b0, 8'd2}) begin
      bad++; $display("FAIL wrap_end got=%h want=%h",
        {exp_state, locked, err, wrap_cnt}, {2'd1, 1'b1, 1'b0, 8'd2});
    end
    total++;
    if (got_a() !== want_a()) begin
      bad++; $display("FAIL wrap_model got=%h want=%h", got_a(), want_a());
    end
  endtask

  task automatic test_hold();
    int seq[5] = '{0, 1, 1, 1, 2};
    cyc(0, 0, 1);
    foreach (seq[i]) cyc(1, seq[i], 0);
    total++;
    if ({exp_state, locked, err, bad_cnt} !== {2'd0, 1'b1, 1'b0, 2'd0}) begin
      bad++; $display("FAIL hold got=%h want=%h",
        {exp_state, locked, err, bad_cnt}, {2'd0, 1'b1, 1'b0, 2'd0});
    end
  endtask

  task automatic test_mismatch();
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    for (int i = 1; i <= 2; i++) begin
      cyc(1, 2, 0);
      total++;
      if (bad_cnt !== 2'(i) || err !== 1'b0) begin
        bad++; $display("FAIL mismatch_cnt got=%0d want=%0d", bad_cnt, i);
      end
    end
    cyc(1, 2, 0);
    total++;
    if ({locked, err} !== 2'b01) begin
      bad++; $display("FAIL mismatch_err got=%b want=01", {locked, err});
    end
    cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 0, 0);
    total++;
    if (wrap_cnt !== 8'd0 || err !== 1'b1 || got_a() !== want_a()) begin
      bad++; $display("FAIL mismatch_frozen got=%h want=%h", got_a(), want_a());
    end
  endtask

  task automatic test_ts3_clr();
    cyc(0, 0, 1);
    cyc(1, 0, 0); cyc(1, 1, 0);
    cyc(1, 3, 0);
    total++;
    if ({locked, err} !== 2'b01) begin
      bad++; $display("FAIL ts3_err got=%b want=01", {locked, err});
    end
    cyc(1, 0, 1);
    total++;
    if (got_a() !== 14'h0) begin
      bad++; $display("FAIL clr_drop got=%h want=%h", got_a(), 14'h0);
    end
  endtask

  task automatic test_sat_async();
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    repeat (5) begin cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 0, 0); end
    total++;
    if (wrap_cnt2 !== 2'd3 || wrap_cnt !== 8'd5) begin
      bad++; $display("FAIL saturate got=%0d/%0d want=3/5", wrap_cnt2, wrap_cnt);
    end
    cyc(1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (got_a() !== 14'h0 || {exp_state2, locked2, err2, bad_cnt2, wrap_cnt2} !== 8'h0) begin
      bad++; $display("FAIL async_rst got=%h want=%h", got_a(), 14'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int s, r;
    bit v, c;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) s = m_exp;
      else if (r < 8) s = m_last;
      else s = $urandom_range(0, 3);
      v = ($urandom_range(0, 4) != 0);
      c = (m_mode == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 49) == 0);
      cyc(v, s, c);
      total++;
      if (got_a() !== want_a()) begin
        bad++; $display("FAIL random_a i=%0d got=%h want=%h", i, got_a(), want_a());
      end
      total++;
      if ({exp_state2, locked2, err2, bad_cnt2, wrap_cnt2} !== want_b()) begin
        bad++; $display("FAIL random_b i=%0d got=%h want=%h", i,
          {exp_state2, locked2, err2, bad_cnt2, wrap_cnt2}, want_b());
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_hold();
    test_mismatch();
    test_ts3_clr();
    test_sat_async();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
